mem_port_arbiter: RTL and testbench

Shares the single memory port of the NPC core between instruction fetch (IF) and load/store (LS). Accepts one request at a time from either requester via a hold-until-grant handshake. Drives it onto the downstream port and routes the response back to the owner. LS has priority, with a starvation guard for IF. Sits between the core datapath (fetch and memory stages) and the DPI-backed memory model.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS); LS wins ties, IF is
// granted after STARVE_LIMIT consecutive LS grants while it waits. Requests are latched at grant.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_q, state_d;
    logic                owner_ls_q, owner_ls_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                if_rvalid_q, ls_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;
    logic                resp;

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        starve_d   = starve_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        mem_req    = 1'b0;
        case (state_q)
            IDLE: begin
                // No grant during reset: the latched request would be discarded.
                if (!rst) begin
                    if (ls_req && !(if_req && starve_q == LIMIT)) ls_gnt = 1'b1;
                    else if (if_req)                              if_gnt = 1'b1;
                end
                if (ls_gnt) begin
                    state_d    = REQ;
                    owner_ls_d = 1'b1;
                    wen_d      = ls_wen;
                    addr_d     = ls_addr;
                    wdata_d    = ls_wdata;
                    wmask_d    = ls_wmask;
                    if (!if_req)                starve_d = '0;
                    else if (starve_q != LIMIT) starve_d = starve_q + 1'b1;
                end else if (if_gnt) begin
                    state_d    = REQ;
                    owner_ls_d = 1'b0;
                    wen_d      = 1'b0;
                    addr_d     = if_addr;
                    wdata_d    = '0;
                    wmask_d    = '0;
                    starve_d   = '0;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp = (state_q == WAIT) && mem_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_ls_q  <= 1'b0;
            starve_q    <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_ls_q  <= owner_ls_d;
            starve_q    <= starve_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            if_rvalid_q <= resp && !owner_ls_q;
            ls_rvalid_q <= resp && owner_ls_q;
            if (resp && owner_ls_q)  ls_rdata_q <= mem_rdata;
            if (resp && !owner_ls_q) if_rdata_q <= mem_rdata;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle vector bench for mem_port_arbiter with STARVE_LIMIT=2.
module tb_mem_port_arbiter;

    localparam logic [63:0] IA  = 64'h8000_0000, LA  = 64'h8000_1000;
    localparam logic [63:0] IA2 = 64'h8000_0004, LA2 = 64'h8000_2000;
    localparam logic [63:0] IA3 = 64'h8000_0008, LA3 = 64'h8000_3000;
    localparam logic [63:0] WD  = 64'hDEAD_BEEF;
    localparam logic [7:0]  WM  = 8'hFF;
    localparam logic [63:0] R1  = 64'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req, ls_wen, ls_gnt, ls_rvalid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask, mem_wmask;
    logic        mem_req, mem_wen, mem_ready, mem_rvalid, busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int ncmp = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic rst; logic ir; logic [63:0] ia; logic lr; logic wen; logic [63:0] la;
        logic rdy; logic rv; logic [63:0] rd;
        logic ig; logic lg; logic mr; logic bz; logic irv; logic lrv;
        logic [63:0] ird; logic [63:0] lrd;
        logic [63:0] ea; logic ew; logic ef; int st;
    } vec_t;

    function automatic vec_t v(
        input logic rst_, input logic ir, input logic [63:0] ia, input logic lr,
        input logic wen, input logic [63:0] la, input logic rdy, input logic rv,
        input logic [63:0] rd, input logic ig, input logic lg, input logic mr,
        input logic bz, input logic irv, input logic lrv, input logic [63:0] ird,
        input logic [63:0] lrd, input logic [63:0] ea, input logic ew, input logic ef,
        input int st);
        vec_t r;
        r.rst = rst_; r.ir = ir; r.ia = ia; r.lr = lr; r.wen = wen; r.la = la;
        r.rdy = rdy; r.rv = rv; r.rd = rd;
        r.ig = ig; r.lg = lg; r.mr = mr; r.bz = bz; r.irv = irv; r.lrv = lrv;
        r.ird = ird; r.lrd = lrd; r.ea = ea; r.ew = ew; r.ef = ef; r.st = st;
        return r;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL row %0d %s: got %h want %h", row, name, act, exp);
        end
    endtask

    vec_t vt[$];

    initial begin
        // ef: 1 = latched fields came from LS (wdata/wmask = WD/WM), 0 = IF or reset (zero)
        //         rst ir ia  lr wen la  rdy rv rd                ig lg mr bz irv lrv ird           lrd           ea   ew ef st
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 0, 0, 0,            0,            0,   0, 0, 0));
        // single fetch
        vt.push_back(v(0, 1, IA, 0, 0, 0,  0, 0, 0,                1, 0, 0, 0, 0, 0, 0,            0,            0,   0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, 0,            0,            IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, R1,               0, 0, 0, 1, 0, 0, 0,            0,            IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 1, 0, R1,           0,            IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 0, 0, R1,           0,            IA,  0, 0, 0));
        // store with 3-cycle mem_ready stall; ls_addr changes after grant
        vt.push_back(v(0, 0, 0,  1, 1, LA, 0, 0, 0,                0, 1, 0, 0, 0, 0, R1,           0,            IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 1, 0,  0, 0, 0,                0, 0, 1, 1, 0, 0, R1,           0,            LA,  1, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 1, 1, 0, 0, R1,           0,            LA,  1, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, IA, 0, 0, 0,                0, 0, 1, 1, 0, 0, R1,           0,            LA,  1, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, R1,           0,            LA,  1, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 0,                0, 0, 0, 1, 0, 0, R1,           0,            LA,  1, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 0, 1, R1,           0,            LA,  1, 1, 0));
        // simultaneous requests: LS first, IF granted in the ls_rvalid cycle
        vt.push_back(v(0, 1, IA2,1, 0, LA2,0, 0, 0,                0, 1, 0, 0, 0, 0, R1,           0,            LA,  1, 1, 0));
        vt.push_back(v(0, 1, IA2,0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, R1,           0,            LA2, 0, 1, 1));
        vt.push_back(v(0, 1, IA2,0, 0, 0,  0, 1, 64'hAAAA,         0, 0, 0, 1, 0, 0, R1,           0,            LA2, 0, 1, 1));
        vt.push_back(v(0, 1, IA2,0, 0, 0,  0, 0, 0,                1, 0, 0, 0, 0, 1, R1,           64'hAAAA,     LA2, 0, 1, 1));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, R1,           64'hAAAA,     IA2, 0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 64'h1111,         0, 0, 0, 1, 0, 0, R1,           64'hAAAA,     IA2, 0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 1, 0, 64'h1111,     64'hAAAA,     IA2, 0, 0, 0));
        // both held continuously: LS, LS, IF, LS, LS, IF
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 0, 0,                0, 1, 0, 0, 0, 0, 64'h1111,     64'hAAAA,     IA2, 0, 0, 0));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,1, 0, 0,                0, 0, 1, 1, 0, 0, 64'h1111,     64'hAAAA,     LA3, 0, 1, 1));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 1, 64'h10,           0, 0, 0, 1, 0, 0, 64'h1111,     64'hAAAA,     LA3, 0, 1, 1));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 0, 0,                0, 1, 0, 0, 0, 1, 64'h1111,     64'h10,       LA3, 0, 1, 1));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,1, 0, 0,                0, 0, 1, 1, 0, 0, 64'h1111,     64'h10,       LA3, 0, 1, 2));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 1, 64'h20,           0, 0, 0, 1, 0, 0, 64'h1111,     64'h10,       LA3, 0, 1, 2));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 0, 0,                1, 0, 0, 0, 0, 1, 64'h1111,     64'h20,       LA3, 0, 1, 2));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,1, 0, 0,                0, 0, 1, 1, 0, 0, 64'h1111,     64'h20,       IA3, 0, 0, 0));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 1, 64'h30,           0, 0, 0, 1, 0, 0, 64'h1111,     64'h20,       IA3, 0, 0, 0));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 0, 0,                0, 1, 0, 0, 1, 0, 64'h30,       64'h20,       IA3, 0, 0, 0));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,1, 0, 0,                0, 0, 1, 1, 0, 0, 64'h30,       64'h20,       LA3, 0, 1, 1));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 1, 64'h40,           0, 0, 0, 1, 0, 0, 64'h30,       64'h20,       LA3, 0, 1, 1));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 0, 0,                0, 1, 0, 0, 0, 1, 64'h30,       64'h40,       LA3, 0, 1, 1));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,1, 0, 0,                0, 0, 1, 1, 0, 0, 64'h30,       64'h40,       LA3, 0, 1, 2));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 1, 64'h50,           0, 0, 0, 1, 0, 0, 64'h30,       64'h40,       LA3, 0, 1, 2));
        vt.push_back(v(0, 1, IA3,1, 0, LA3,0, 0, 0,                1, 0, 0, 0, 0, 1, 64'h30,       64'h50,       LA3, 0, 1, 2));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, 64'h30,       64'h50,       IA3, 0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 64'h60,           0, 0, 0, 1, 0, 0, 64'h30,       64'h50,       IA3, 0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 1, 0, 64'h60,       64'h50,       IA3, 0, 0, 0));
        // reset in WAIT, stale mem_rvalid next cycle, then a normal load
        vt.push_back(v(0, 1, IA, 0, 0, 0,  0, 0, 0,                1, 0, 0, 0, 0, 0, 64'h60,       64'h50,       IA3, 0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, 64'h60,       64'h50,       IA,  0, 0, 0));
        vt.push_back(v(1, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 1, 0, 0, 64'h60,       64'h50,       IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 64'hBAD,          0, 0, 0, 0, 0, 0, 0,            0,            0,   0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 0, 0, 0,            0,            0,   0, 0, 0));
        vt.push_back(v(0, 0, 0,  1, 0, LA, 0, 0, 0,                0, 1, 0, 0, 0, 0, 0,            0,            0,   0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, 0,            0,            LA,  0, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 64'h5555,         0, 0, 0, 1, 0, 0, 0,            0,            LA,  0, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 0, 1, 0,            64'h5555,     LA,  0, 1, 0));
        // mem_rvalid in IDLE and REQ must be ignored
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 64'h9999,         0, 0, 0, 0, 0, 0, 0,            64'h5555,     LA,  0, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 0, 0, 0,            64'h5555,     LA,  0, 1, 0));
        vt.push_back(v(0, 1, IA, 0, 0, 0,  0, 1, 64'h9999,         1, 0, 0, 0, 0, 0, 0,            64'h5555,     LA,  0, 1, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 64'h9999,         0, 0, 1, 1, 0, 0, 0,            64'h5555,     IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 1, 1, 0, 0, 0,            64'h5555,     IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  1, 0, 0,                0, 0, 1, 1, 0, 0, 0,            64'h5555,     IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 1, 64'h7777,         0, 0, 0, 1, 0, 0, 0,            64'h5555,     IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 1, 0, 64'h7777,     64'h5555,     IA,  0, 0, 0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,  0, 0, 0,                0, 0, 0, 0, 0, 0, 64'h7777,     64'h5555,     IA,  0, 0, 0));

        rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wen = 1'b0;
        ls_addr = '0; ls_wdata = WD; ls_wmask = WM;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            #1;
            rst        = vt[i].rst;
            if_req     = vt[i].ir;
            if_addr    = vt[i].ia;
            ls_req     = vt[i].lr;
            ls_wen     = vt[i].wen;
            ls_addr    = vt[i].la;
            mem_ready  = vt[i].rdy;
            mem_rvalid = vt[i].rv;
            mem_rdata  = vt[i].rd;
            @(negedge clk);
            chk("if_gnt",    i, 64'(if_gnt),    64'(vt[i].ig));
            chk("ls_gnt",    i, 64'(ls_gnt),    64'(vt[i].lg));
            chk("mem_req",   i, 64'(mem_req),   64'(vt[i].mr));
            chk("busy",      i, 64'(busy),      64'(vt[i].bz));
            chk("if_rvalid", i, 64'(if_rvalid), 64'(vt[i].irv));
            chk("ls_rvalid", i, 64'(ls_rvalid), 64'(vt[i].lrv));
            chk("if_rdata",  i, if_rdata,       vt[i].ird);
            chk("ls_rdata",  i, ls_rdata,       vt[i].lrd);
            chk("mem_addr",  i, mem_addr,       vt[i].ea);
            chk("mem_wen",   i, 64'(mem_wen),   64'(vt[i].ew));
            chk("mem_wdata", i, mem_wdata,      vt[i].ef ? WD : 64'h0);
            chk("mem_wmask", i, 64'(mem_wmask), vt[i].ef ? 64'(WM) : 64'h0);
            chk("starve",    i, 64'(dut.starve_q), 64'(vt[i].st));
            @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
